// File: rtl/mux_nto1_rr_pkg.sv
// Shared definitions for the N:1 registered multiplexer: mode encodings and a
// ceiling-log2 helper used to validate the select width at elaboration.
package mux_nto1_rr_pkg;

  localparam int MUX_MODE_SEL = 0;
  localparam int MUX_MODE_RR  = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_nto1_rr_arbiter.sv
// Round-robin arbiter: finds the first requesting channel at or above ptr
// (wrapping) and moves ptr just past the winner whenever a grant is consumed.
module mux_nto1_rr_arbiter
  import mux_nto1_rr_pkg::*;
#(
  parameter int NCH  = 8,
  parameter int SELW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NCH-1:0]  req,
  input  logic            adv,
  output logic [SELW-1:0] grant_idx,
  output logic            grant_vld
);

  localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

  logic [SELW-1:0] ptr;
  logic [NCH-1:0]  rot;
  logic [SELW-1:0] off;
  logic [SELW:0]   sum;
  logic [SELW-1:0] nxt;

  // Rotating a doubled request vector puts ptr at bit 0, so the lowest set
  // bit of the rotated view is the next channel in round-robin order.
  always_comb begin
    rot       = NCH'({req, req} >> ptr);
    off       = '0;
    grant_vld = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off       = SELW'(i);
        grant_vld = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NCH_W) sum = sum - NCH_W;
    grant_idx = sum[SELW-1:0];
    if (grant_idx == SELW'(NCH - 1)) nxt = '0;
    else                             nxt = grant_idx + SELW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ptr <= '0;
    else if (adv) ptr <= nxt;
  end

endmodule

// File: rtl/mux_nto1_rr.sv
// N-channel, WIDTH-bit multiplexer with a single registered output stage and
// valid/ready flow control; channel choice is external select or round-robin.
module mux_nto1_rr
  import mux_nto1_rr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 8,
  parameter int SELW  = 3,
  parameter int MODE  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SELW-1:0]    sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]     in_valid,
  output logic [NCH-1:0]     in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_ch
);

  localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

  if (SELW != clog2(NCH) || NCH < 2 || NCH > 16) begin : g_bad_params
    $error("mux_nto1_rr: SELW must equal clog2(NCH) and NCH must be 2..16");
  end

  logic            load;
  logic            xfer;
  logic [SELW-1:0] grant_idx;
  logic            grant_vld;

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic [SELW-1:0]  ch_p1;

  // The register can take a word when empty or when its current word leaves now.
  assign load = ~vld_p1 | out_ready;

  if (MODE == MUX_MODE_RR) begin : g_rr
    logic unused_sel;
    assign unused_sel = ^sel;

    mux_nto1_rr_arbiter #(
      .NCH  (NCH),
      .SELW (SELW)
    ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (in_valid),
      .adv       (xfer),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
    );
  end else begin : g_sel
    assign grant_idx = sel;
    assign grant_vld = ({1'b0, sel} < NCH_W);
  end

  // rst_n gates the handshake so nothing is offered while reset is held.
  assign xfer = rst_n & load & grant_vld & in_valid[grant_idx];

  for (genvar g = 0; g < NCH; g++) begin : g_rdy
    assign in_ready[g] = rst_n & load & grant_vld & (grant_idx == SELW'(g));
  end

  // ---- stage p1: output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
    end else if (load) begin
      vld_p1 <= xfer;
      if (xfer) begin
        data_p1 <= in_data[grant_idx*WIDTH +: WIDTH];
        ch_p1   <= grant_idx;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_ch    = ch_p1;

endmodule
